// File: rtl/bram_single_macro.sv
// ---------------------------------------------------------------------------
// bram_single_macro
//
// Single-port block RAM shaped after the FPGA 18Kb/36Kb BRAM primitive. One
// address is shared by reads and writes. Writes are masked per byte lane. The
// read is synchronous into an output latch. An optional output pipeline
// register follows the latch. The output stages reset asynchronously to
// SRVAL. The storage array itself is never cleared by reset.
//
// Parameters
//   BRAM_SIZE  : "18Kb" (16 Kib data) or "36Kb" (32 Kib data)
//   WIDTH      : data width, 1..36 for "18Kb", 1..72 for "36Kb"
//   DO_REG     : 0 = one-cycle read latency, 1 = extra register gated by regce_i
//   WRITE_MODE : "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE"
//   SRVAL      : value forced into the output stages while rst_ni is low
//   INIT_FILE  : time-zero contents selector, "NONE" = zeros
//
// Ports
//   clk_i    in   1       clock, rising edge
//   rst_ni   in   1       asynchronous active-low reset of the output stages
//   en_i     in   1       port enable, gates every read and write
//   regce_i  in   1       output register clock enable (DO_REG=1 only)
//   we_i     in   WE_W    per-lane write enables
//   addr_i   in   ADDR_W  word address
//   di_i     in   WIDTH   write data
//   do_o     out  WIDTH   read data
// ---------------------------------------------------------------------------
module bram_single_macro #(
    parameter string             BRAM_SIZE  = "18Kb",
    parameter int                WIDTH      = 32,
    parameter int                DO_REG     = 0,
    parameter string             WRITE_MODE = "WRITE_FIRST",
    parameter logic [WIDTH-1:0]  SRVAL      = '0,
    parameter string             INIT_FILE  = "NONE",
    // The primitive's parity bits do not count toward depth, so 9/18/36/72
    // bit widths fall into the 8/16/32/64 buckets.
    localparam int PW     = (WIDTH <= 1)  ? 1  :
                            (WIDTH <= 2)  ? 2  :
                            (WIDTH <= 4)  ? 4  :
                            (WIDTH <= 9)  ? 8  :
                            (WIDTH <= 18) ? 16 :
                            (WIDTH <= 36) ? 32 : 64,
    localparam int DEPTH  = ((BRAM_SIZE == "36Kb") ? 32768 : 16384) / PW,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int WE_W   = (WIDTH > 36) ? 8 :
                            (WIDTH > 18) ? 4 :
                            (WIDTH > 9)  ? 2 : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              regce_i,
    input  logic [WE_W-1:0]   we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  di_i,
    output logic [WIDTH-1:0]  do_o
);

    localparam bit IS_WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
    localparam bit IS_READ_FIRST  = (WRITE_MODE == "READ_FIRST");

    // -----------------------------------------------------------------------
    // Elaboration-time legality checks
    // -----------------------------------------------------------------------
    if (BRAM_SIZE != "18Kb" && BRAM_SIZE != "36Kb") begin : g_badSize
        $fatal(1, "bram_single_macro: BRAM_SIZE must be \"18Kb\" or \"36Kb\"");
    end

    if (WIDTH < 1 || (BRAM_SIZE == "18Kb" && WIDTH > 36) || WIDTH > 72) begin : g_badWidth
        $fatal(1, "bram_single_macro: WIDTH %0d illegal for BRAM_SIZE %s", WIDTH, BRAM_SIZE);
    end

    if (!IS_WRITE_FIRST && !IS_READ_FIRST && WRITE_MODE != "NO_CHANGE") begin : g_badMode
        $fatal(1, "bram_single_macro: unknown WRITE_MODE %s", WRITE_MODE);
    end

    if (DO_REG != 0 && DO_REG != 1) begin : g_badDoReg
        $fatal(1, "bram_single_macro: DO_REG must be 0 or 1");
    end

    // -----------------------------------------------------------------------
    // Storage array with time-zero contents
    // -----------------------------------------------------------------------
    typedef logic [WIDTH-1:0] memArr_t [DEPTH];

    // Builds the power-up image: all zeros.
    function automatic memArr_t loadInit();
        memArr_t tmp;
        for (int i = 0; i < DEPTH; i++) begin
            tmp[i] = '0;
        end
        return tmp;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH] = loadInit();

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_oldWord;
    logic [WIDTH-1:0] w_newWord;
    logic             w_wrAny;
    logic [WIDTH-1:0] r_latch;

    // Byte lanes: lane i owns bits [8i+7:8i]. The top lane also owns any
    // leftover upper bits, so a 36-bit word has lane 3 = [35:24].
    for (genvar i = 0; i < WE_W; i++) begin : g_lane
        localparam int LO = 8 * i;
        localparam int HI = (i == WE_W - 1) ? WIDTH - 1 : 8 * i + 7;
        assign w_mask[HI:LO] = {(HI - LO + 1){we_i[i]}};
    end

    assign w_wrAny   = |we_i;
    assign w_oldWord = r_mem[addr_i];
    assign w_newWord = (w_oldWord & ~w_mask) | (di_i & w_mask);

    // Array write port. There is deliberately no reset here. A write still
    // lands while rst_ni is low, because reset only touches the output stages.
    always_ff @(posedge clk_i) begin
        if (en_i && w_wrAny) begin
            r_mem[addr_i] <= w_newWord;
        end
    end

    // Output latch. A plain read loads the addressed word. During a write,
    // WRITE_MODE picks the post-write word, the pre-write word, or a hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_latch <= SRVAL;
        end else if (en_i) begin
            if (!w_wrAny) begin
                r_latch <= w_oldWord;
            end else if (IS_WRITE_FIRST) begin
                r_latch <= w_newWord;
            end else if (IS_READ_FIRST) begin
                r_latch <= w_oldWord;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Optional output pipeline register
    // -----------------------------------------------------------------------
    if (DO_REG == 1) begin : g_doReg
        logic [WIDTH-1:0] r_doReg;

        // The output register advances on regce_i alone. It keeps shifting
        // the latch forward even while the port is disabled.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_doReg <= SRVAL;
            end else if (regce_i) begin
                r_doReg <= r_latch;
            end
        end

        assign do_o = r_doReg;
    end else begin : g_noReg
        logic w_unusedRegce;
        assign w_unusedRegce = regce_i;
        assign do_o          = r_latch;
    end

endmodule

// File: tb/tb_bram_single_macro.sv
// ---------------------------------------------------------------------------
// tb_bram_single_macro
//
// Runs five bram_single_macro instances from one shared stimulus stream:
//   uWf  : 18Kb x32, WRITE_FIRST, DO_REG=0
//   uRf  : 18Kb x32, READ_FIRST,  DO_REG=0
//   uNc  : 18Kb x32, NO_CHANGE,   DO_REG=0
//   uReg : 18Kb x32, WRITE_FIRST, DO_REG=1
//   u72  : 36Kb x72, WRITE_FIRST, DO_REG=0 (8 write lanes)
// A word-level reference model predicts every output after every edge.
// ---------------------------------------------------------------------------
module tb_bram_single_macro;

    localparam logic [31:0] SRV32  = 32'hDEADBEEF;
    localparam logic [31:0] SRVREG = 32'h0BADF00D;
    localparam logic [71:0] SRV72  = 72'h12_3456_789A_BCDE_F012;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;
    logic        en_i   = 1'b0;
    logic        regce_i = 1'b0;
    logic [3:0]  we32   = '0;
    logic [31:0] di32   = '0;
    logic [7:0]  we72   = '0;
    logic [71:0] di72   = '0;
    logic [8:0]  addr_i = '0;

    logic [31:0] doWf, doRf, doNc, doReg;
    logic [71:0] do72;

    always #5 clk_i = ~clk_i;

    bram_single_macro #(.BRAM_SIZE("18Kb"), .WIDTH(32), .DO_REG(0),
        .WRITE_MODE("WRITE_FIRST"), .SRVAL(SRV32), .INIT_FILE("NONE")) uWf (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .regce_i(regce_i),
        .we_i(we32), .addr_i(addr_i), .di_i(di32), .do_o(doWf));

    bram_single_macro #(.BRAM_SIZE("18Kb"), .WIDTH(32), .DO_REG(0),
        .WRITE_MODE("READ_FIRST"), .SRVAL(SRV32), .INIT_FILE("NONE")) uRf (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .regce_i(regce_i),
        .we_i(we32), .addr_i(addr_i), .di_i(di32), .do_o(doRf));

    bram_single_macro #(.BRAM_SIZE("18Kb"), .WIDTH(32), .DO_REG(0),
        .WRITE_MODE("NO_CHANGE"), .SRVAL(SRV32), .INIT_FILE("NONE")) uNc (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .regce_i(regce_i),
        .we_i(we32), .addr_i(addr_i), .di_i(di32), .do_o(doNc));

    bram_single_macro #(.BRAM_SIZE("18Kb"), .WIDTH(32), .DO_REG(1),
        .WRITE_MODE("WRITE_FIRST"), .SRVAL(SRVREG), .INIT_FILE("NONE")) uReg (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .regce_i(regce_i),
        .we_i(we32), .addr_i(addr_i), .di_i(di32), .do_o(doReg));

    bram_single_macro #(.BRAM_SIZE("36Kb"), .WIDTH(72), .DO_REG(0),
        .WRITE_MODE("WRITE_FIRST"), .SRVAL(SRV72), .INIT_FILE("NONE")) u72 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .regce_i(regce_i),
        .we_i(we72), .addr_i(addr_i), .di_i(di72), .do_o(do72));

    // Reference model state
    logic [31:0] m32 [512];
    logic [71:0] m72 [512];
    logic [31:0] eWf, eRf, eNc, eLat3, eReg;
    logic [71:0] e72;

    int checks   = 0;
    int failures = 0;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Replaces the enabled lanes of oldW with newW. Lane i is bits 8i..8i+7,
    // and the last lane stretches to the top of the word.
    function automatic logic [71:0] mergeLanes(input logic [71:0] oldW, input logic [71:0] newW,
                                               input logic [7:0] we, input int width, input int lanes);
        logic [71:0] mask = '0;
        for (int i = 0; i < lanes; i++) begin
            int lo = 8 * i;
            int nb = (i == lanes - 1) ? width - lo : 8;
            if (((we >> i) & 8'd1) != 8'd0) begin
                mask = mask | (((72'd1 << nb) - 72'd1) << lo);
            end
        end
        return (oldW & ~mask) | (newW & mask);
    endfunction

    function automatic void forceResetModel();
        eWf   = SRV32;
        eRf   = SRV32;
        eNc   = SRV32;
        eLat3 = SRVREG;
        eReg  = SRVREG;
        e72   = SRV72;
    endfunction

    // Drives one cycle, advances the model across the edge, then checks all outputs.
    task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] di,
                                 input logic [7:0] w8, input logic [71:0] d72,
                                 input logic [8:0] a, input logic rce);
        logic [31:0] old32, new32;
        logic [71:0] old72, new72;
        en_i    = en;
        we32    = we;
        di32    = di;
        we72    = w8;
        di72    = d72;
        addr_i  = a;
        regce_i = rce;
        @(posedge clk_i);
        if (rce) eReg = eLat3;
        if (en) begin
            old32 = m32[a];
            new32 = 32'(mergeLanes(72'(old32), 72'(di), 8'(we), 32, 4));
            if (we != 4'd0) m32[a] = new32;
            eWf   = new32;
            eLat3 = new32;
            eRf   = old32;
            if (we == 4'd0) eNc = old32;
            old72 = m72[a];
            new72 = mergeLanes(old72, d72, w8, 72, 8);
            if (w8 != 8'd0) m72[a] = new72;
            e72 = new72;
        end
        if (!rst_ni) forceResetModel();
        #1;
        checkOutput("wf",  72'(doWf),  72'(eWf));
        checkOutput("rf",  72'(doRf),  72'(eRf));
        checkOutput("nc",  72'(doNc),  72'(eNc));
        checkOutput("reg", 72'(doReg), 72'(eReg));
        checkOutput("w72", do72, e72);
    endtask

    initial begin
        logic [8:0] ra;
        for (int i = 0; i < 512; i++) begin
            m32[i] = '0;
            m72[i] = '0;
        end
        forceResetModel();

        // Asynchronous reset between edges
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rstWf",  72'(doWf),  72'(SRV32));
        checkOutput("rstRf",  72'(doRf),  72'(SRV32));
        checkOutput("rstReg", 72'(doReg), 72'(SRVREG));
        checkOutput("rst72",  do72, SRV72);

        // Writes during reset still reach the array
        applyStimulus(1, 4'hF, 32'hCAFE0009, 8'hFF, 72'hAB_CDEF_0123_4567_89AB, 9'd9, 1);
        applyStimulus(0, 4'h0, 32'h0, 8'h0, 72'h0, 9'd0, 1);
        rst_ni = 1'b1;

        // First reads after release
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd0, 1);
        checkOutput("rdAddr0", 72'(doWf), 72'h0);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd9, 1);
        checkOutput("rdRstWrite", 72'(doWf), 72'hCAFE0009);

        // Full-word writes and readback, top address does not alias zero
        applyStimulus(1, 4'hF, 32'h11223344, 8'h0, 72'h0, 9'd5, 1);
        applyStimulus(1, 4'hF, 32'hA5A5A5A5, 8'h0, 72'h0, 9'd511, 1);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd5, 1);
        checkOutput("rdAddr5", 72'(doWf), 72'h11223344);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd511, 1);
        checkOutput("rdAddr511", 72'(doWf), 72'hA5A5A5A5);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd0, 1);
        checkOutput("noAlias", 72'(doWf), 72'h0);

        // Byte-lane merge
        applyStimulus(1, 4'hF, 32'h11223344, 8'h0, 72'h0, 9'd7, 1);
        applyStimulus(1, 4'b0101, 32'hAABBCCDD, 8'h0, 72'h0, 9'd7, 1);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd7, 1);
        checkOutput("laneMerge", 72'(doWf), 72'h11BB33DD);

        // Write-mode behaviour on a write to a word holding 1
        applyStimulus(1, 4'hF, 32'h1, 8'h0, 72'h0, 9'd3, 1);
        applyStimulus(1, 4'hF, 32'h2, 8'h0, 72'h0, 9'd3, 1);
        checkOutput("modeWf", 72'(doWf), 72'h2);
        checkOutput("modeRf", 72'(doRf), 72'h1);
        checkOutput("modeNc", 72'(doNc), 72'h11BB33DD);

        // Port disabled: no write, outputs hold
        applyStimulus(0, 4'hF, 32'hFFFFFFFF, 8'hFF, {72{1'b1}}, 9'd5, 0);
        checkOutput("enHold", 72'(doWf), 72'h2);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd5, 1);
        checkOutput("enNoWrite", 72'(doWf), 72'h11223344);

        // Output register: two-cycle latency, regce_i=0 holds
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd5, 1);
        checkOutput("doRegLat", 72'(doReg), 72'h11223344);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd511, 0);
        applyStimulus(1, 4'h0, 32'h0, 8'h0, 72'h0, 9'd511, 0);
        checkOutput("doRegHold", 72'(doReg), 72'h11223344);

        // 72-bit top lane spans bits [71:56]
        applyStimulus(1, 4'h0, 32'h0, 8'h80, {72{1'b1}}, 9'd2, 1);
        applyStimulus(1, 4'h0, 32'h0, 8'h00, 72'h0, 9'd2, 1);
        checkOutput("lane7", do72, {16'hFFFF, 56'h0});

        // Randomized traffic on a few low and high addresses, with one reset burst
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_ni = 1'b0;
                #1;
                forceResetModel();
                checkOutput("midRst", 72'(doWf), 72'(SRV32));
            end
            if (i == 203) rst_ni = 1'b1;
            ra = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(504, 511));
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                          $urandom,
                          ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom),
                          {8'($urandom), $urandom, $urandom},
                          ra,
                          $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
